// File: rtl/booth_mult_controller_pkg.sv
// Shared encodings for the radix-2 Booth multiplier.
// Imported by the step datapath and the controller.
package booth_mult_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_controller_step.sv
// One combinational radix-2 Booth add/shift step.
// A is one bit wider than M so A +/- M never wraps.
module booth_step
  import booth_mult_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
    // arithmetic shift of {A,Q,q_1}
    a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_controller.sv
// Sequential radix-2 Booth signed multiplier controller.
// Owns the FSM, counter and datapath registers.
module booth_mult_controller
  import booth_mult_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             result_rdy,
  output logic             exception,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   a_r;
  logic             q_1_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_s;
  logic [WIDTH-1:0] q_s;
  logic             q_1_s;
  logic             ovf;

  logic load;
  logic step;
  logic done;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a      (a_r),
    .q      (q_r),
    .q_1    (q_1_r),
    .m      (m_r),
    .a_nxt  (a_s),
    .q_nxt  (q_s),
    .q_1_nxt(q_1_s)
  );

  // upper half must be a pure sign extension of the low half
  assign ovf = (a_s != {(WIDTH+1){q_s[WIDTH-1]}});

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (start) begin
          load = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_r        <= '0;
      q_r        <= '0;
      a_r        <= '0;
      q_1_r      <= 1'b0;
      cnt        <= '0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      result_rdy <= done;
      if (load) begin
        m_r   <= data_a;
        q_r   <= data_b;
        a_r   <= '0;
        q_1_r <= 1'b0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (step) begin
        a_r   <= a_s;
        q_r   <= q_s;
        q_1_r <= q_1_s;
        cnt   <= cnt + CW'(1);
      end
      if (done) begin
        result    <= q_s;
        exception <= ovf;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_controller.sv
// Self-checking bench for booth_mult_controller.
// Product model plus directed literal checks.
module tb_booth_mult_controller;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic [W-1:0] result;
  logic         result_rdy;
  logic         exception;
  logic         busy;

  booth_mult_controller #(
    .WIDTH(W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_a    (data_a),
    .data_b    (data_b),
    .result    (result),
    .result_rdy(result_rdy),
    .exception (exception),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  bit           m_busy = 1'b0;
  bit           m_rdy  = 1'b0;
  bit           m_exc  = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_res  = '0;
  longint       m_prod = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: exact 64-bit product, ready W edges after start.
  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b0;
      m_exc  <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      m_prod <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_prod <= longint'($signed(data_a)) * longint'($signed(data_b));
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_rdy  <= 1'b1;
          m_res  <= m_prod[W-1:0];
          m_exc  <= (m_prod != longint'($signed(m_prod[W-1:0])));
        end
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("mon_rdy", 64'(result_rdy), 64'(m_rdy));
      chk("mon_busy", 64'(busy), 64'(m_busy));
      chk("mon_res", 64'(result), 64'(m_res));
      chk("mon_exc", 64'(exception), 64'(m_exc));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    data_a = a;
    data_b = b;
    tick();
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
  endtask

  task automatic wait_rdy(input string nm, input logic [W-1:0] er,
                          input logic ee);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (result_rdy) got = 1'b1;
    end
    chk({nm, "_lat"}, got ? 64'(n) : 64'(0), 64'(W));
    chk({nm, "_res"}, 64'(result), 64'(er));
    chk({nm, "_exc"}, 64'(exception), 64'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    chk("rst_res", 64'(result), 64'(0));
    chk("rst_rdy", 64'(result_rdy), 64'(0));
    chk("rst_exc", 64'(exception), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    start_op(32'd6, 32'd7);
    @(negedge clock);
    chk("busy_6x7", 64'(busy), 64'(1));
    wait_rdy("m6x7", 32'd42, 1'b0);
    repeat (3) tick();
    @(negedge clock);
    chk("hold_res", 64'(result), 64'(42));
    chk("hold_rdy", 64'(result_rdy), 64'(0));

    start_op(32'hFFFF_FFFB, 32'd3);
    wait_rdy("mn5x3", 32'hFFFF_FFF1, 1'b0);
    start_op(32'd3, 32'hFFFF_FFFB);
    wait_rdy("m3xn5", 32'hFFFF_FFF1, 1'b0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy("mminxn1", 32'h8000_0000, 1'b1);
    start_op(32'h8000_0000, 32'd1);
    wait_rdy("mminx1", 32'h8000_0000, 1'b0);
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_rdy("m2p16sq", 32'd0, 1'b1);

    start_op(32'd6, 32'd7);
    repeat (9) tick();
    start_op(32'd9, 32'hFFFF_FFFE);
    wait_rdy("abort", 32'hFFFF_FFEE, 1'b0);

    start_op(32'd6, 32'd7);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      chk("postrst_rdy", 64'(result_rdy), 64'(0));
      chk("postrst_busy", 64'(busy), 64'(0));
      chk("postrst_res", 64'(result), 64'(0));
    end

    start_op(32'd6, 32'd7);
    repeat (31) tick();
    start_op(32'd2, 32'd3);
    @(negedge clock);
    chk("coll_rdy", 64'(result_rdy), 64'(0));
    chk("coll_res", 64'(result), 64'(0));
    chk("coll_busy", 64'(busy), 64'(1));
    wait_rdy("coll", 32'd6, 1'b0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_controller.md
Name: booth_mult_controller

Overview:
- Sequential radix-2 Booth signed multiplier for the CPU's multdiv unit; the multiply counterpart of the non-restoring division step path.
- Latches two WIDTH-bit two's-complement operands on a start pulse and runs one Booth add/shift step per cycle for WIDTH cycles.
- Returns the low WIDTH bits of the product with a one-cycle ready pulse and an overflow exception flag.

Parameters:
WIDTH, 32, operand, result and iteration count width.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; latches data_a and data_b
data_a  input  WIDTH  multiplicand M, signed
data_b  input  WIDTH  multiplier Q, signed
result  output  WIDTH  low WIDTH bits of data_a*data_b; held until the next completion
result_rdy  output  1  one-cycle pulse; result and exception are valid
exception  output  1  product not representable in signed WIDTH bits; valid with result_rdy and held
busy  output  1  high while an operation is in progress

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on the rising edge of clock.
- Reset values: result=0, exception=0, result_rdy=0, busy=0, state=IDLE, counter=0, A=0, Q=0, q_1=0, M=0.
- Reset asserted mid-operation aborts the operation: no result_rdy, outputs return to reset values.
- Reset has priority over start.
- Datapath:
  - M register, WIDTH bits.
  - A accumulator, WIDTH+1 bits, sign-extended. The extra bit keeps A+/-M exact when M = -2^(WIDTH-1).
  - Q register, WIDTH bits.
  - q_1 bit.
  - counter, clog2(WIDTH)+1 bits.
- States: IDLE, RUN.
- IDLE:
  - If start=1: M<=data_a, Q<=data_b, A<=0, q_1<=0, counter<=0, busy<=1, go to RUN.
  - result_rdy<=0.
- RUN, one Booth step per edge:
  - The pair {Q[0],q_1} selects the A update: 01 -> A+M (M sign-extended to WIDTH+1); 10 -> A-M; 00 or 11 -> A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1. The new A MSB replicates the old A MSB.
  - counter<=counter+1.
- Completion at the step edge where counter==WIDTH-1:
  - result<= new Q.
  - exception<=1 iff the bits of the new A are not all equal to new Q[WIDTH-1]. This is an upper-half vs. sign mismatch, i.e. signed overflow.
  - result_rdy<=1, busy<=0, go to IDLE.
- Latency:
  - start sampled at edge E0; steps occur at edges E1..E(WIDTH).
  - result_rdy is high for the single cycle following edge E(WIDTH), i.e. WIDTH cycles after the start edge.
  - result_rdy deasserts at the next edge unless a new operation completes.
- start while busy: abort and restart with the new operands. The counter reloads to 0 and no result_rdy is issued for the aborted operation.
- start on the same edge as completion: completion is suppressed (result_rdy<=0, result and exception keep their prior values) and the new operation starts.
- Operands are sampled only at the start edge. Changes to data_a and data_b during RUN have no effect.
- Wrap-around: counter never exceeds WIDTH-1 in RUN. No overflow of the counter is reachable.

Decomposition:
- Shared include file holds:
  - state encodings (IDLE=1'b0, RUN=1'b1)
  - the Booth pair encodings (2'b01 add, 2'b10 subtract)
- One combinational sub-module, booth_step. It takes A, Q, q_1 and M and returns next A, Q and q_1 for one add/shift step. The controller instantiates it once and owns the registers, counter and FSM.
- The adder inside booth_step uses the team's existing ALU add/subtract op at WIDTH+1 bits. Alternatively it uses native +/-, but the choice must be applied consistently.

Test Plan:
- reset, then start with data_a=6, data_b=7 -> busy=1 for 32 cycles; result_rdy pulses exactly 32 cycles after the start edge with result=42, exception=0; result stays 42 afterwards.
- data_a=-5 (0xFFFFFFFB), data_b=3 -> result=0xFFFFFFF1 (-15), exception=0; repeat with data_a=3, data_b=-5 -> same.
- data_a=0x80000000, data_b=0xFFFFFFFF -> result=0x80000000, exception=1.
- data_a=0x80000000, data_b=1 -> result=0x80000000, exception=0.
- data_a=0x00010000, data_b=0x00010000 -> result=0, exception=1.
- start 6*7, then at cycle 10 start 9*(-2) -> no ready for 42; ready exactly 32 cycles after the second start with result=0xFFFFFFEE, exception=0.
- start 6*7, then reset at cycle 15 -> busy=0 and result_rdy stays 0 thereafter; result=0.
- start 6*7, then start 2*3 on the completion edge -> result_rdy stays 0 on that cycle; result=6 appears 32 cycles later.
